// File: rtl/regs_access_ctrl.sv
// regs_access_ctrl: debug read/write/clear access to the register file's debug port, yielding to core writes (dbg_* request side, core_we_i/core_stall_o core side, rf_jtag_* register file side)
module regs_access_ctrl #(
  parameter int ADDR_W     = 5,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              dbg_req_i,
  input  logic              dbg_we_i,
  input  logic [ADDR_W-1:0] dbg_addr_i,
  input  logic [DATA_W-1:0] dbg_wdata_i,
  output logic              dbg_gnt_o,
  output logic              dbg_rvalid_o,
  output logic [DATA_W-1:0] dbg_rdata_o,
  input  logic              dbg_clr_i,
  output logic              dbg_clr_done_o,
  input  logic              core_we_i,
  output logic              core_stall_o,
  output logic              rf_jtag_we_o,
  output logic [ADDR_W-1:0] rf_jtag_addr_o,
  output logic [DATA_W-1:0] rf_jtag_data_o,
  input  logic [DATA_W-1:0] rf_jtag_rdata_i,
  output logic              busy_o
);
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(31);
  typedef enum logic [1:0] {IDLE, WRITE, READ, CLEAR} state_e;
  state_e state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d, idx_q, idx_d;
  logic [DATA_W-1:0] data_q, data_d, rdata_q, rdata_d;
  logic [SW-1:0] starve_q, starve_d;
  logic stall_q, stall_d, pend_q, pend_d, rvalid_q, rvalid_d, done_q, done_d;
  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    data_d         = data_q;
    idx_d          = idx_q;
    starve_d       = starve_q;
    rdata_d        = rdata_q;
    pend_d         = pend_q | dbg_clr_i;
    rvalid_d       = 1'b0;
    done_d         = 1'b0;
    dbg_gnt_o      = 1'b0;
    rf_jtag_we_o   = 1'b0;
    rf_jtag_addr_o = '0;
    rf_jtag_data_o = '0;
    case (state_q)
      IDLE: begin
        pend_d = 1'b0;
        if (dbg_clr_i || pend_q) begin
          state_d = CLEAR;
          idx_d   = ADDR_W'(1);
        end else if (dbg_req_i) begin
          dbg_gnt_o = 1'b1;
          addr_d    = dbg_addr_i;
          data_d    = dbg_we_i ? dbg_wdata_i : data_q;
          starve_d  = '0;
          state_d   = dbg_we_i ? WRITE : READ;
        end
      end
      WRITE: begin
        rf_jtag_addr_o = addr_q;
        rf_jtag_data_o = data_q;
        if (addr_q == '0) begin
          state_d = IDLE;
        end else if (!core_we_i) begin
          rf_jtag_we_o = 1'b1;
          state_d      = IDLE;
        end else begin
          starve_d = (starve_q == SMAX) ? starve_q : starve_q + SW'(1);
        end
      end
      READ: begin
        rf_jtag_addr_o = addr_q;
        rdata_d        = (addr_q == '0) ? '0 : rf_jtag_rdata_i;
        rvalid_d       = 1'b1;
        state_d        = IDLE;
      end
      CLEAR: begin
        rf_jtag_addr_o = idx_q;
        if (!core_we_i) begin
          rf_jtag_we_o = 1'b1;
          idx_d        = idx_q + ADDR_W'(1);
          state_d      = (idx_q == LAST) ? IDLE : CLEAR;
          done_d       = (idx_q == LAST);
        end
      end
      default: state_d = IDLE;
    endcase
    if (!rst_ni) begin
      dbg_gnt_o    = 1'b0;
      rf_jtag_we_o = 1'b0;
    end
    stall_d = (state_d == CLEAR) || (state_d == WRITE && starve_d == SMAX);
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      data_q   <= '0;
      idx_q    <= '0;
      starve_q <= '0;
      rdata_q  <= '0;
      stall_q  <= 1'b0;
      pend_q   <= 1'b0;
      rvalid_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      idx_q    <= idx_d;
      starve_q <= starve_d;
      rdata_q  <= rdata_d;
      stall_q  <= stall_d;
      pend_q   <= pend_d;
      rvalid_q <= rvalid_d;
      done_q   <= done_d;
    end
  end
  assign dbg_rvalid_o   = rvalid_q;
  assign dbg_rdata_o    = rdata_q;
  assign dbg_clr_done_o = done_q;
  assign core_stall_o   = stall_q;
  assign busy_o         = (state_q != IDLE);
endmodule

// File: tb/tb_regs_access_ctrl.sv
// tb_regs_access_ctrl: randomized transactions against a transaction-level model of the register file
module tb_regs_access_ctrl;
  localparam int SMAX = 8;
  logic clk = 0, rst_ni = 0;
  logic dbg_req_i = 0, dbg_we_i = 0, dbg_clr_i = 0, core_we_i = 0;
  logic [4:0] dbg_addr_i = '0;
  logic [31:0] dbg_wdata_i = '0;
  logic dbg_gnt_o, dbg_rvalid_o, dbg_clr_done_o, core_stall_o, rf_jtag_we_o, busy_o;
  logic [31:0] dbg_rdata_o, rf_jtag_data_o, rf_jtag_rdata_i;
  logic [4:0] rf_jtag_addr_o;
  logic [31:0] rf [32];
  logic [31:0] ref_rf [32];
  logic preload = 1;
  int wr_cnt = 0;
  int n_checks = 0, n_errs = 0;
  regs_access_ctrl #(.ADDR_W(5), .DATA_W(32), .STARVE_MAX(SMAX)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .dbg_req_i(dbg_req_i), .dbg_we_i(dbg_we_i),
    .dbg_addr_i(dbg_addr_i), .dbg_wdata_i(dbg_wdata_i), .dbg_gnt_o(dbg_gnt_o),
    .dbg_rvalid_o(dbg_rvalid_o), .dbg_rdata_o(dbg_rdata_o), .dbg_clr_i(dbg_clr_i),
    .dbg_clr_done_o(dbg_clr_done_o), .core_we_i(core_we_i), .core_stall_o(core_stall_o),
    .rf_jtag_we_o(rf_jtag_we_o), .rf_jtag_addr_o(rf_jtag_addr_o), .rf_jtag_data_o(rf_jtag_data_o),
    .rf_jtag_rdata_i(rf_jtag_rdata_i), .busy_o(busy_o)
  );
  always #5 clk = ~clk;
  assign rf_jtag_rdata_i = rf[rf_jtag_addr_o];
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 32; i++) rf[i] <= ref_rf[i];
    end else if (rf_jtag_we_o) begin
      rf[rf_jtag_addr_o] <= rf_jtag_data_o;
      wr_cnt <= wr_cnt + 1;
    end
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  always @(negedge clk) check("we_vs_core", 32'(rf_jtag_we_o & core_we_i), 32'd0);
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check_zero(input string tag);
    check(tag, {21'd0, busy_o, dbg_gnt_o, dbg_rvalid_o, dbg_clr_done_o, core_stall_o, rf_jtag_we_o, rf_jtag_addr_o}, 32'd0);
    check("zero_rdata", dbg_rdata_o, 32'd0);
    check("zero_rfdata", rf_jtag_data_o, 32'd0);
  endtask
  task automatic reset_cycle();
    int w0;
    dbg_req_i = 0; dbg_clr_i = 0; core_we_i = 0; rst_ni = 0;
    @(negedge clk);
    check("rst_cyc_we", 32'(rf_jtag_we_o), 32'd0);
    check("rst_cyc_gnt", 32'(dbg_gnt_o), 32'd0);
    w0 = wr_cnt;
    tick();
    rst_ni = 1;
    @(negedge clk);
    check_zero("post_rst");
    tick();
    @(negedge clk);
    check("post_rst_done", 32'(dbg_clr_done_o), 32'd0);
    check("post_rst_wr", 32'(wr_cnt), 32'(w0));
    tick();
  endtask
  task automatic do_write(input logic [4:0] a, input logic [31:0] d, input int b, input bit clr_pulse);
    dbg_req_i = 1; dbg_we_i = 1; dbg_addr_i = a; dbg_wdata_i = d; dbg_clr_i = 0; core_we_i = 1'($urandom);
    @(negedge clk);
    check("wr_gnt", 32'(dbg_gnt_o), 32'd1);
    check("wr_idle", {30'd0, busy_o, core_stall_o}, 32'd0);
    tick();
    dbg_req_i = 0; dbg_addr_i = 5'($urandom); dbg_wdata_i = $urandom;
    if (a == 0) begin
      core_we_i = 1'($urandom);
      @(negedge clk);
      check("wr0_we", 32'(rf_jtag_we_o), 32'd0);
      check("wr0_busy", 32'(busy_o), 32'd1);
      tick();
    end else begin
      for (int j = 1; j <= b; j++) begin
        core_we_i = 1; dbg_clr_i = clr_pulse && j <= 2;
        @(negedge clk);
        check("wr_blk_we", 32'(rf_jtag_we_o), 32'd0);
        check("wr_blk_stall", 32'(core_stall_o), 32'(j - 1 >= SMAX));
        check("wr_blk_gnt", 32'(dbg_gnt_o), 32'd0);
        tick();
      end
      core_we_i = 0; dbg_clr_i = clr_pulse && b == 0;
      @(negedge clk);
      check("wr_we", 32'(rf_jtag_we_o), 32'd1);
      check("wr_addr", 32'(rf_jtag_addr_o), 32'(a));
      check("wr_data", rf_jtag_data_o, d);
      check("wr_stall", 32'(core_stall_o), 32'(b >= SMAX));
      ref_rf[a] = d;
      tick();
      dbg_clr_i = 0;
    end
  endtask
  task automatic do_read(input logic [4:0] a);
    logic [31:0] exp;
    exp = (a == 0) ? 32'd0 : ref_rf[a];
    dbg_req_i = 1; dbg_we_i = 0; dbg_addr_i = a; dbg_clr_i = 0; core_we_i = 1'($urandom);
    @(negedge clk);
    check("rd_gnt", 32'(dbg_gnt_o), 32'd1);
    check("rd_idle", {30'd0, busy_o, core_stall_o}, 32'd0);
    tick();
    dbg_req_i = 0; dbg_addr_i = 5'($urandom);
    @(negedge clk);
    check("rd_addr", 32'(rf_jtag_addr_o), 32'(a));
    check("rd_mid", {29'd0, busy_o, dbg_rvalid_o, rf_jtag_we_o}, 32'd4);
    tick();
    @(negedge clk);
    check("rd_rvalid", 32'(dbg_rvalid_o), 32'd1);
    check("rd_rdata", dbg_rdata_o, exp);
    tick();
    @(negedge clk);
    check("rd_rvalid_end", 32'(dbg_rvalid_o), 32'd0);
    check("rd_rdata_hold", dbg_rdata_o, exp);
    tick();
  endtask
  task automatic clear_op(input bit with_req, input bit pending, input bit toggle);
    int idx, cyc;
    bit ph;
    logic [4:0] ra;
    ra = 5'($urandom);
    dbg_clr_i = !pending; core_we_i = 1'($urandom);
    dbg_req_i = with_req; dbg_we_i = 0; dbg_addr_i = ra;
    @(negedge clk);
    check("clr_start_gnt", 32'(dbg_gnt_o), 32'd0);
    check("clr_start_idle", {30'd0, busy_o, core_stall_o}, 32'd0);
    tick();
    dbg_clr_i = 0;
    idx = 1; cyc = 0; ph = 1'($urandom);
    while (idx < 32 && cyc < 300) begin
      core_we_i = toggle ? (ph ^ 1'(cyc)) : 1'($urandom);
      @(negedge clk);
      check("clr_stall", 32'(core_stall_o), 32'd1);
      check("clr_busy", 32'(busy_o), 32'd1);
      check("clr_gnt_done", {30'd0, dbg_gnt_o, dbg_clr_done_o}, 32'd0);
      check("clr_we", 32'(rf_jtag_we_o), 32'(!core_we_i));
      if (!core_we_i) begin
        check("clr_addr", 32'(rf_jtag_addr_o), 32'(idx));
        check("clr_data", rf_jtag_data_o, 32'd0);
        ref_rf[idx] = 0;
        idx++;
      end
      cyc++;
      tick();
    end
    check("clr_bound", 32'(idx), 32'd32);
    core_we_i = 0;
    @(negedge clk);
    check("clr_done", 32'(dbg_clr_done_o), 32'd1);
    check("clr_end_idle", {30'd0, busy_o, core_stall_o}, 32'd0);
    check("clr_end_gnt", 32'(dbg_gnt_o), 32'(with_req));
    tick();
    dbg_req_i = 0;
    @(negedge clk);
    check("clr_done_once", 32'(dbg_clr_done_o), 32'd0);
    if (with_req) begin
      check("clr_req_addr", 32'(rf_jtag_addr_o), 32'(ra));
      tick();
      @(negedge clk);
      check("clr_req_rvalid", 32'(dbg_rvalid_o), 32'd1);
      check("clr_req_rdata", dbg_rdata_o, 32'd0);
    end
    tick();
  endtask
  task automatic reset_in_clear();
    dbg_clr_i = 1; core_we_i = 0;
    tick();
    dbg_clr_i = 0;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      check("rc_addr", {26'd0, rf_jtag_we_o, rf_jtag_addr_o}, 32'(c) | 32'h20);
      ref_rf[c] = 0;
      tick();
    end
    reset_cycle();
  endtask
  task automatic reset_in_write();
    dbg_req_i = 1; dbg_we_i = 1; dbg_addr_i = 9; dbg_wdata_i = $urandom;
    tick();
    dbg_req_i = 0;
    for (int j = 1; j <= 10; j++) begin
      core_we_i = 1;
      tick();
    end
    @(negedge clk);
    check("rw_stall", 32'(core_stall_o), 32'd1);
    reset_cycle();
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
  initial begin
    int op;
    for (int i = 0; i < 32; i++) ref_rf[i] = $urandom;
    ref_rf[0] = ref_rf[0] | 32'h1;
    tick();
    tick();
    @(negedge clk);
    check_zero("reset");
    preload = 0;
    rst_ni = 1;
    tick();
    do_write(5'd5, 32'hDEADBEEF, 0, 0);
    do_write(5'd3, $urandom, 10, 0);
    do_write(5'd7, 32'h12345678, 0, 0);
    do_read(5'd0);
    do_read(5'd7);
    reset_in_clear();
    clear_op(0, 0, 1);
    clear_op(1, 0, 0);
    do_write(5'd12, $urandom, 3, 1);
    clear_op(0, 1, 0);
    reset_in_write();
    for (int n = 0; n < 30; n++) begin
      op = $urandom_range(0, 9);
      if (op < 4) do_write(($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)), $urandom, $urandom_range(0, 11), 0);
      else if (op < 8) do_read(5'($urandom));
      else if (op == 8) clear_op(1'($urandom), 0, 1'($urandom));
      else begin
        do_write(5'($urandom_range(1, 31)), $urandom, $urandom_range(0, 4), 1);
        clear_op(1'($urandom), 1, 0);
      end
    end
    for (int i = 0; i < 32; i++) check("rf_final", rf[i], ref_rf[i]);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end
endmodule
